// File: rtl/pipeline_pkg.sv
// Shared types and constants for the ARM pipeline stages.
package pipeline_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;

    // MOV R0,R0: the architectural no-op used as the pipeline bubble.
    localparam instr_t      NOP_INSTR = 32'hE1A0_0000;
    localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Pipeline register with enable and synchronous clear; clear beats enable.
module pipe_reg_en_clr #(
    parameter int unsigned W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RST_VAL;
        end else if (clr_i) begin
            q_q <= RST_VAL;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, next-PC selection, IF/ID register and stall/bubble counters.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               PCSrcW,
    input  logic [ADDR_W-1:0]  ResultW,
    input  logic               BranchTakenE,
    input  logic [ADDR_W-1:0]  ALUResultE,
    input  logic [INSTR_W-1:0] InstrF,
    output logic [ADDR_W-1:0]  PCF,
    output logic [INSTR_W-1:0] InstrD,
    output logic [ADDR_W-1:0]  PCPlus8D,
    output logic               ValidD,
    output logic [CNT_W-1:0]   StallCnt,
    output logic [CNT_W-1:0]   BubbleCnt
);

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] pc_plus8;
    logic [ADDR_W-1:0] pc_next;
    logic              redirect;
    logic              pc_en;
    logic              ifid_en;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0]  bubble_cnt_d, bubble_cnt_q;

    assign pc_plus4 = PCF + ADDR_W'(PC_INC);
    assign pc_plus8 = pc_plus4 + ADDR_W'(PC_INC);
    assign redirect = BranchTakenE | PCSrcW;
    // A redirect must land even while fetch is stalled, or the target is lost.
    assign pc_en    = redirect | ~StallF;
    assign ifid_en  = ~StallD;

    always_comb begin
        pc_next = pc_plus4;
        if (BranchTakenE) begin
            pc_next = ALUResultE;
        end else if (PCSrcW) begin
            pc_next = ResultW;
        end
    end

    pipe_reg_en_clr #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (pc_en),
        .clr_i (1'b0),
        .d_i   (pc_next),
        .q_o   (PCF)
    );

    pipe_reg_en_clr #(.W(INSTR_W), .RST_VAL(INSTR_W'(NOP_INSTR))) u_instr_d_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (ifid_en),
        .clr_i (FlushD),
        .d_i   (InstrF),
        .q_o   (InstrD)
    );

    pipe_reg_en_clr #(.W(ADDR_W), .RST_VAL('0)) u_pc_plus8_d_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (ifid_en),
        .clr_i (FlushD),
        .d_i   (pc_plus8),
        .q_o   (PCPlus8D)
    );

    pipe_reg_en_clr #(.W(1), .RST_VAL(1'b0)) u_valid_d_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (ifid_en),
        .clr_i (FlushD),
        .d_i   (1'b1),
        .q_o   (ValidD)
    );

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (StallF && !redirect && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (FlushD && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign StallCnt  = stall_cnt_q;
    assign BubbleCnt = bubble_cnt_q;

endmodule
